mem_unit_be: RTL

Parametrised successor to the single-port-pair scratch memory. Adds per-byte write strobes, a selectable 1- or 2-cycle read pipeline with a valid flag, read-during-write forwarding, and out-of-range address error flags. An optional post-reset clear engine zeroes every location before the block accepts traffic. Sits as the local data/scratch RAM behind the core load/store unit.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_init_ctrl.sv | 58 +++++
 rtl/mem_unit_be.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the scratch memory and its clear controller.
package mem_pkg;

    // Clear-engine states: INIT zero-fills the array, READY serves traffic.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int unsigned ByteW       = 8;
    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefNumLanes = DefDataW / ByteW;

    // Byte lanes in a data word.
    function automatic int unsigned num_lanes(input int unsigned dw);
        return dw / ByteW;
    endfunction

    // Index width for a depth; at least one bit so a depth of 1 still has a counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) w = w + 1;
        return w;
    endfunction

    // Byte-lane merge: take the new byte where the strobe is set, else keep the old one.
    function automatic logic [ByteW-1:0] byte_merge(input logic [ByteW-1:0] old_b,
                                                    input logic [ByteW-1:0] new_b,
                                                    input logic             strb);
        return strb ? new_b : old_b;
    endfunction

endpackage

// File: rtl/mem_init_ctrl.sv
// Post-reset clear engine: walks every word writing zero, then hands the
// array write port to the user path.
module mem_init_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned MemDepth     = 256,
    parameter int unsigned IdxW         = 8,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 usr_we_i,
    input  logic [IdxW-1:0]      usr_idx_i,
    input  logic [DataWidth-1:0] usr_wdata_i,
    output logic                 arr_we_o,
    output logic [IdxW-1:0]      arr_idx_o,
    output logic [DataWidth-1:0] arr_wdata_o,
    output logic                 init_busy_o
);

    init_state_e     state_q, state_d;
    logic [IdxW-1:0] cnt_q, cnt_d;

    // State and clear counter; a reset mid-clear restarts the fill from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (ClearOnReset != 0) ? INIT : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and write-port mux: the clear engine owns the port while in INIT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        arr_we_o    = usr_we_i;
        arr_idx_o   = usr_idx_i;
        arr_wdata_o = usr_wdata_i;
        init_busy_o = 1'b0;
        case (state_q)
            INIT: begin
                init_busy_o = 1'b1;
                arr_we_o    = 1'b1;
                arr_idx_o   = cnt_q;
                arr_wdata_o = '0;
                if (cnt_q == IdxW'(MemDepth - 1)) state_d = READY;
                else                              cnt_d   = cnt_q + IdxW'(1);
            end
            READY: ;
            default: state_d = READY;
        endcase
    end

endmodule

// File: rtl/mem_unit_be.sv
// Byte-strobed scratch RAM with 1/2-cycle read pipeline, same-cycle
// forwarding, range checking and an optional zero-fill after reset.
module mem_unit_be
    import mem_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned MemDepth     = 256,
    parameter int unsigned RdLatency    = 1,
    parameter int unsigned WriteFirst   = 1,
    parameter int unsigned ClearOnReset = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [31:0]                     wr_addr,
    input  logic [num_lanes(DataWidth)-1:0] wr_strb,
    input  logic [DataWidth-1:0]            d_in,
    input  logic                            rd_req,
    input  logic [31:0]                     rd_addr,
    output logic [DataWidth-1:0]            data_out,
    output logic                            rd_valid,
    output logic                            rd_err,
    output logic                            wr_err,
    output logic                            init_busy
);

    localparam int unsigned Lanes = num_lanes(DataWidth);
    localparam int unsigned IdxW  = clog2(MemDepth);

    logic [DataWidth-1:0] mem_q [MemDepth];

    logic                 wr_in_rng, rd_in_rng, usr_we, rd_fire, rd_fwd;
    logic [IdxW-1:0]      wr_idx, rd_idx, arr_idx;
    logic [DataWidth-1:0] wr_old, wr_merged, rd_data, arr_wdata;
    logic                 arr_we;
    logic                 src_vld, src_err;
    logic [DataWidth-1:0] src_data;
    logic [DataWidth-1:0] data_out_q;
    logic                 rd_valid_q, rd_err_q, wr_err_q;

    // Full 32-bit compare so upper address bits can never alias into the array.
    assign wr_in_rng = wr_addr < MemDepth;
    assign rd_in_rng = rd_addr < MemDepth;
    assign wr_idx    = wr_addr[IdxW-1:0];
    assign rd_idx    = rd_addr[IdxW-1:0];
    assign usr_we    = ~init_busy & wr_en & wr_in_rng;
    assign rd_fire   = ~init_busy & rd_req;
    assign wr_old    = mem_q[wr_idx];

    // Strobed write word; also the forwarded value for a same-address read.
    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        assign wr_merged[l*ByteW +: ByteW] =
            byte_merge(wr_old[l*ByteW +: ByteW], d_in[l*ByteW +: ByteW], wr_strb[l]);
    end

    assign rd_fwd  = (WriteFirst != 0) && usr_we && (wr_idx == rd_idx);
    assign rd_data = !rd_in_rng ? '0 : (rd_fwd ? wr_merged : mem_q[rd_idx]);

    mem_init_ctrl #(
        .DataWidth    (DataWidth),
        .MemDepth     (MemDepth),
        .IdxW         (IdxW),
        .ClearOnReset (ClearOnReset)
    ) u_init (
        .clk         (clk),
        .rst_n       (rst_n),
        .usr_we_i    (usr_we),
        .usr_idx_i   (wr_idx),
        .usr_wdata_i (wr_merged),
        .arr_we_o    (arr_we),
        .arr_idx_o   (arr_idx),
        .arr_wdata_o (arr_wdata),
        .init_busy_o (init_busy)
    );

    // Array storage; not reset, only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (arr_we) mem_q[arr_idx] <= arr_wdata;
    end

    if (RdLatency == 2) begin : g_lat2
        logic                 p_vld_q, p_err_q;
        logic [DataWidth-1:0] p_data_q;

        // Extra read stage; in-flight reads are dropped by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p_vld_q  <= 1'b0;
                p_err_q  <= 1'b0;
                p_data_q <= '0;
            end else begin
                p_vld_q  <= rd_fire;
                p_err_q  <= ~rd_in_rng;
                if (rd_fire) p_data_q <= rd_data;
            end
        end

        assign src_vld  = p_vld_q;
        assign src_err  = p_err_q;
        assign src_data = p_data_q;
    end else begin : g_lat1
        assign src_vld  = rd_fire;
        assign src_err  = ~rd_in_rng;
        assign src_data = rd_data;
    end

    // Output stage: data holds between reads, error flags are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= src_vld;
            rd_err_q   <= src_vld & src_err;
            wr_err_q   <= ~init_busy & wr_en & ~wr_in_rng;
            if (src_vld) data_out_q <= src_data;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_err_q;

endmodule
